multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the 16-bit MicroProcessor datapath.
- Produces the 3-bit ALU control code and every datapath strobe.
- Consumes the ALU's zero flag to resolve branches, and handshakes with instruction/data memory through mem_ready.
- Sits beside the ALU, register file and memory as the single sequencer of the core.

Parameters:
- HALT_EN, 1: 1 = opcode 1111 enters HALT; 0 = opcode 1111 is a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- is_zero  in  1  ALU zero flag, combinational from current ALU inputs.
- mem_ready  in  1  memory completes current read/write this cycle.
- alu_control  out  3  000 add, 001 sub, 010 sll, 011 srl, 100 and, 101 or, 110 xor, 111 not.
- alu_src_a  out  1  0 = PC, 1 = regA.
- alu_src_b  out  2  00 regB, 01 const 1, 10 sext(imm6), 11 sext(imm6) for branch offset.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[15:12],IR[11:0]}.
- reg_write  out  1  register-file write.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination: 0 = IR[8:6], 1 = IR[11:9].
- halted  out  1  FSM in HALT.
- state  out  4  current state, for debug.

Behaviour:
- Opcodes:
  - 0xxx: R-type; alu_control = opcode[2:0].
  - 1000 ADDI, 1001 LW, 1010 SW, 1011 BEQ, 1100 BNE, 1101 JMP.
  - 1110: NOP.
  - 1111: HALT.
- States: FETCH 0, DECODE 1, EXEC_R 2, WB_ALU 3, ADDR 4, MEM_RD 5, WB_MEM 6, MEM_WR 7, BRANCH 8, JUMP 9, HALT 10.
- Outputs are Moore-style, decoded from state. pc_write is the only output also gated by inputs (mem_ready / is_zero). Unlisted strobes are 0; alu_control defaults to 000.
- Reset:
  - State register loads FETCH on the next edge.
  - While reset is high, every strobe is forced 0: mem_read, mem_write, ir_write, pc_write, reg_write.
  - Forced-zero and reset values: alu_control 000, selects 0, halted 0, state 0.
  - Reset mid-instruction aborts it; no partial write may occur.
- FETCH: i_or_d 0, mem_read 1, alu_src_a 0, alu_src_b 01, add.
  - While mem_ready = 0: stay, ir_write 0, pc_write 0.
  - On mem_ready = 1: ir_write 1, pc_write 1 (pc_src 00), go DECODE.
- DECODE: alu_src_a 0, alu_src_b 11, add (branch target into ALUOut). Next state by opcode:
  - 0xxx → EXEC_R; 1000 → EXEC_R with imm.
  - 1001, 1010 → ADDR.
  - 1011, 1100 → BRANCH.
  - 1101 → JUMP.
  - 1110 → FETCH.
  - 1111 → HALT if HALT_EN, else FETCH.
- EXEC_R: alu_src_a 1.
  - R-type: alu_src_b 00, alu_control = opcode[2:0].
  - ADDI: alu_src_b 10, add.
  - Next: WB_ALU.
- WB_ALU: reg_write 1, mem_to_reg 0, reg_dst 1 → FETCH.
- ADDR: alu_src_a 1, alu_src_b 10, add → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: i_or_d 1, mem_read 1. Hold until mem_ready, then → WB_MEM.
- WB_MEM: reg_write 1, mem_to_reg 1, reg_dst 1 → FETCH.
- MEM_WR: i_or_d 1, mem_write 1. Hold until mem_ready, then → FETCH.
  - mem_write stays high for the whole wait.
- BRANCH: alu_src_a 1, alu_src_b 00, sub, pc_src 01.
  - pc_write = is_zero for BEQ, !is_zero for BNE.
  - Always → FETCH; branch costs 3 cycles.
- JUMP: pc_src 10, pc_write 1 → FETCH.
- HALT: halted 1, all strobes 0. Left only by reset.
- Latencies with zero-wait memory:
  - R/ADDI: 4 cycles. LW: 5. SW: 4. BEQ/BNE: 3. JMP: 3. NOP: 2.
  - Each memory wait cycle adds 1.
- Illegal state encodings (11–15) → FETCH on the next edge, strobes 0.

Decomposition:
- Shared include mp_defs.vh holds:
  - Opcode constants, ALU control codes (also used by the ALU).
  - State encodings, alu_src_b and pc_src select codes.
- One sub-module, alu_op_decoder: combinational (state, opcode) → alu_control, alu_src_a, alu_src_b. The FSM instantiates it.

Test Plan:
- Reset held 3 cycles mid-MEM_WR → mem_write 0 during reset; state 0 the cycle after release; no reg_write or pc_write pulse.
- Opcode 0110 (XOR), mem_ready always 1 → states 0,1,2,3,0; alu_control 110 in EXEC_R; reg_write high exactly 1 cycle.
- LW, mem_ready low 2 cycles in FETCH and 3 in MEM_RD → total 10 cycles; ir_write one pulse; reg_write only in WB_MEM with mem_to_reg 1.
- BEQ with is_zero 1, then BNE with is_zero 1 → pc_write 1 in BRANCH for BEQ and 0 for BNE; alu_control 001 in BRANCH for both.
- JMP → pc_src 10 and pc_write 1 in state 9; next state FETCH.
- Opcode 1111 with HALT_EN=1 → halted 1 and strobes 0 indefinitely; with HALT_EN=0 → returns to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MicroProcessor control path:
// opcodes, ALU codes, FSM state encodings and datapath select codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_ALU = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_LW   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_ONE   = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_BROFF = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic is_rtype(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// Combinational ALU operand/operation selection from the current FSM state
// and the instruction opcode.
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  opcode,
    output logic [2:0]  alu_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b
);

    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        case (state)
            S_FETCH: begin
                alu_src_b = SRC_B_ONE;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_BROFF;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                if (is_rtype(opcode)) begin
                    alu_control = opcode[2:0];
                end else begin
                    alu_src_b = SRC_B_IMM;
                end
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 16-bit MicroProcessor: one FSM that drives
// every datapath strobe and select, resolving branches from the ALU zero flag.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        is_zero,
    input  logic        mem_ready,
    output logic [2:0]  alu_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        halted,
    output logic [3:0]  state
);

    state_t      state_q;
    state_t      state_next;
    logic [2:0]  dec_alu_control;
    logic        dec_alu_src_a;
    logic [1:0]  dec_alu_src_b;

    alu_op_decoder u_alu_op_decoder (
        .state       (state_q),
        .opcode      (opcode),
        .alu_control (dec_alu_control),
        .alu_src_a   (dec_alu_src_a),
        .alu_src_b   (dec_alu_src_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Memory handshake: mem_read/mem_write is held high as a request for as
    // long as the FSM sits in an access state; the access completes on the
    // cycle mem_ready is high, and only then does the FSM move on.
    always_comb begin
        state_next  = state_q;
        alu_control = dec_alu_control;
        alu_src_a   = dec_alu_src_a;
        alu_src_b   = dec_alu_src_b;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_rtype(opcode) || opcode == OP_ADDI) begin
                    state_next = S_EXEC_R;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:   state_next = S_ADDR;
                        OP_BEQ, OP_BNE: state_next = S_BRANCH;
                        OP_JMP:         state_next = S_JUMP;
                        OP_HALT:        state_next = HALT_EN ? S_HALT : S_FETCH;
                        default:        state_next = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R: state_next = S_WB_ALU;
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_BRANCH: begin
                pc_src     = PC_SRC_ALUOUT;
                pc_write   = (opcode == OP_BEQ) ? is_zero : !is_zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset overrides combinationally so an aborted instruction can never
        // complete a write on the reset cycle itself.
        if (reset) begin
            alu_control = ALU_ADD;
            alu_src_a   = 1'b0;
            alu_src_b   = SRC_B_REG;
            i_or_d      = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = PC_SRC_ALU;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            reg_dst     = 1'b0;
            halted      = 1'b0;
        end
    end

    assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle paths derived from the
// latency rules, a per-cycle output model, and literal pins on key strobes.
module tb_multicycle_control;

    localparam int W = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        is_zero;
    logic        mem_ready;

    logic [2:0]  a_alu_control, b_alu_control;
    logic        a_alu_src_a, b_alu_src_a;
    logic [1:0]  a_alu_src_b, b_alu_src_b;
    logic        a_i_or_d, b_i_or_d, a_mem_read, b_mem_read, a_mem_write, b_mem_write;
    logic        a_ir_write, b_ir_write, a_pc_write, b_pc_write;
    logic [1:0]  a_pc_src, b_pc_src;
    logic        a_reg_write, b_reg_write, a_mem_to_reg, b_mem_to_reg, a_reg_dst, b_reg_dst;
    logic        a_halted, b_halted;
    logic [3:0]  a_state, b_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];
    logic         br_pw_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rw_cnt = 0;
    int irw_cnt = 0;
    int pcw_cnt = 0;
    int mw_cnt = 0;
    logic [2:0] exec_alu = 3'b000;
    logic [2:0] br_alu = 3'b000;
    logic [1:0] jmp_pcs = 2'b00;
    logic       last_m2r = 1'b0;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    multicycle_control #(.HALT_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
        .alu_control(a_alu_control), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
        .reg_write(a_reg_write), .mem_to_reg(a_mem_to_reg), .reg_dst(a_reg_dst),
        .halted(a_halted), .state(a_state)
    );

    multicycle_control #(.HALT_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
        .alu_control(b_alu_control), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
        .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg), .reg_dst(b_reg_dst),
        .halted(b_halted), .state(b_state)
    );

    wire [W-1:0] vec_a = {a_state, a_halted, a_alu_control, a_alu_src_a, a_alu_src_b,
                          a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_pc_write,
                          a_pc_src, a_reg_write, a_mem_to_reg, a_reg_dst};
    wire [W-1:0] vec_b = {b_state, b_halted, b_alu_control, b_alu_src_a, b_alu_src_b,
                          b_i_or_d, b_mem_read, b_mem_write, b_ir_write, b_pc_write,
                          b_pc_src, b_reg_write, b_mem_to_reg, b_reg_dst};

    // ---------------- model ----------------
    // st < 0 means reset is asserted this cycle: every output is zero.
    function automatic logic [W-1:0] model_vec(int st, logic [3:0] op, logic rdy, logic z);
        logic [3:0] s;
        logic       h, sa, iod, mr, mw, irw, pcw, rw, m2r, rd;
        logic [2:0] alu;
        logic [1:0] sb, pcs;
        s = (st < 0) ? 4'd0 : 4'(st);
        {h, sa, iod, mr, mw, irw, pcw, rw, m2r, rd} = '0;
        alu = 3'b000; sb = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin sb = 2'b01; mr = 1'b1; irw = rdy; pcw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; if (op < 4'd8) alu = op[2:0]; else sb = 2'b10; end
            3:  begin rw = 1'b1; rd = 1'b1; end
            4:  begin sa = 1'b1; sb = 2'b10; end
            5:  begin iod = 1'b1; mr = 1'b1; end
            6:  begin rw = 1'b1; m2r = 1'b1; rd = 1'b1; end
            7:  begin iod = 1'b1; mw = 1'b1; end
            8:  begin sa = 1'b1; alu = 3'b001; pcs = 2'b01; pcw = (op == 4'b1011) ? z : !z; end
            9:  begin pcs = 2'b10; pcw = 1'b1; end
            10: h = 1'b1;
            default: begin end
        endcase
        return {s, h, alu, sa, sb, iod, mr, mw, irw, pcw, pcs, rw, m2r, rd};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom_range(0, 15));
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("cycle_halt_en1", 32'(vec_a), 32'(exp_q.pop_front()));
            check("cycle_halt_en0", 32'(vec_b), 32'(exp_b_q.pop_front()));
            if (a_reg_write) begin rw_cnt++; last_m2r = a_mem_to_reg; end
            if (a_ir_write) irw_cnt++;
            if (a_pc_write) pcw_cnt++;
            if (a_mem_write) mw_cnt++;
            if (a_state == 4'd2) exec_alu = a_alu_control;
            if (a_state == 4'd8) begin br_pw_q.push_back(a_pc_write); br_alu = a_alu_control; end
            if (a_state == 4'd9) jmp_pcs = a_pc_src;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(int st_a, int st_b, logic [3:0] op, logic rdy, logic z, logic rst);
        reset = rst; opcode = op; mem_ready = rdy; is_zero = z;
        exp_q.push_back(model_vec(st_a, op, rdy, z));
        exp_b_q.push_back(model_vec(st_b, op, rdy, z));
        @(posedge clk);
        #1;
    endtask

    task automatic step(int st, logic [3:0] op, logic rdy, logic z);
        drive(st, st, op, rdy, z, 1'b0);
        cyc++;
    endtask

    task automatic run_instr(logic [3:0] op, int fwait, int mwait, logic z);
        cyc = 0; rw_cnt = 0; irw_cnt = 0; pcw_cnt = 0; mw_cnt = 0;
        for (int i = 0; i < fwait; i++) step(0, ro(), 1'b0, rb());
        step(0, ro(), 1'b1, rb());
        step(1, op, rb(), rb());
        if (op < 4'd8 || op == 4'b1000) begin
            step(2, op, rb(), rb());
            step(3, op, rb(), rb());
        end else if (op == 4'b1001) begin
            step(4, op, rb(), rb());
            for (int i = 0; i < mwait; i++) step(5, op, 1'b0, rb());
            step(5, op, 1'b1, rb());
            step(6, op, rb(), rb());
        end else if (op == 4'b1010) begin
            step(4, op, rb(), rb());
            for (int i = 0; i < mwait; i++) step(7, op, 1'b0, rb());
            step(7, op, 1'b1, rb());
        end else if (op == 4'b1011 || op == 4'b1100) begin
            step(8, op, rb(), z);
        end else if (op == 4'b1101) begin
            step(9, op, rb(), rb());
        end
    endtask

    task automatic check_branch(string name, logic exp_pw);
        if (br_pw_q.size() == 1) check(name, 32'(br_pw_q.pop_front()), 32'(exp_pw));
        else begin check({name, "_seen"}, br_pw_q.size(), 1); br_pw_q.delete(); end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; opcode = 4'd0; is_zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) drive(-1, -1, ro(), 1'b1, rb(), 1'b1);
        reset = 1'b0;
        #1;
        check("reset_release_state", 32'(a_state), 0);
        check("reset_release_fetch_read", 32'(a_mem_read), 1);

        // XOR, zero-wait memory
        run_instr(4'b0110, 0, 0, 1'b0);
        check("xor_latency", cyc, 4);
        check("xor_exec_alu", 32'(exec_alu), 32'(3'b110));
        check("xor_reg_write_cycles", rw_cnt, 1);

        // LW with 2 fetch waits and 3 read waits
        run_instr(4'b1001, 2, 3, 1'b0);
        check("lw_latency", cyc, 10);
        check("lw_ir_write_pulses", irw_cnt, 1);
        check("lw_reg_write_cycles", rw_cnt, 1);
        check("lw_mem_to_reg", 32'(last_m2r), 1);

        // BEQ taken, BNE not taken (both with is_zero=1)
        run_instr(4'b1011, 0, 0, 1'b1);
        check("beq_latency", cyc, 3);
        check_branch("beq_pc_write", 1'b1);
        check("beq_alu", 32'(br_alu), 32'(3'b001));
        run_instr(4'b1100, 0, 0, 1'b1);
        check_branch("bne_pc_write", 1'b0);
        check("bne_alu", 32'(br_alu), 32'(3'b001));
        run_instr(4'b1100, 1, 0, 1'b0);
        check_branch("bne_taken_pc_write", 1'b1);

        // JMP
        run_instr(4'b1101, 0, 0, 1'b0);
        check("jmp_latency", cyc, 3);
        check("jmp_pc_src", 32'(jmp_pcs), 32'(2'b10));
        check("jmp_pc_write_pulses", pcw_cnt, 2);

        // assorted others
        run_instr(4'b1000, 0, 0, 1'b0);
        check("addi_latency", cyc, 4);
        run_instr(4'b1010, 0, 1, 1'b0);
        check("sw_latency", cyc, 5);
        check("sw_write_cycles", mw_cnt, 2);
        run_instr(4'b1110, 0, 0, 1'b0);
        check("nop_latency", cyc, 2);
        run_instr(4'b0100, 1, 0, 1'b0);
        check("and_exec_alu", 32'(exec_alu), 32'(3'b100));
        run_instr(4'b0011, 0, 0, 1'b0);
        check("srl_exec_alu", 32'(exec_alu), 32'(3'b011));

        // reset held 3 cycles in the middle of a stalled store
        rw_cnt = 0; pcw_cnt = 0; mw_cnt = 0;
        step(0, ro(), 1'b1, rb());
        step(1, 4'b1010, rb(), rb());
        step(4, 4'b1010, rb(), rb());
        step(7, 4'b1010, 1'b0, rb());
        step(7, 4'b1010, 1'b0, rb());
        repeat (3) drive(-1, -1, 4'b1010, 1'b1, rb(), 1'b1);
        reset = 1'b0;
        #1;
        check("abort_state_after_release", 32'(a_state), 0);
        check("abort_pc_write_pulses", pcw_cnt, 1);
        check("abort_reg_write_cycles", rw_cnt, 0);
        check("abort_write_cycles", mw_cnt, 2);

        // HALT: enabled instance parks in HALT, disabled one returns to FETCH
        drive(0, 0, ro(), 1'b1, rb(), 1'b0);
        drive(1, 1, 4'b1111, rb(), rb(), 1'b0);
        repeat (5) drive(10, 0, 4'b1111, 1'b0, rb(), 1'b0);
        check("halt_en1_halted", 32'(a_halted), 1);
        check("halt_en1_state", 32'(a_state), 10);
        check("halt_en0_halted", 32'(b_halted), 0);
        check("halt_en0_state", 32'(b_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
